// File: rtl/saturn_inst_decoder.sv
// Saturn CPU instruction-nibble decoder: P=n, GOC/GOTO/GOSUB, optional long jumps (8C-8F).
// Long-jump decoding is enabled by defining SATURN_DEC_LONGJMP_EN.
module saturn_inst_decoder (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clk_en,
    input  logic [3:0]  i_phases,
    input  logic [1:0]  i_phase,
    input  logic [31:0] i_cycle_ctr,
    input  logic        i_bus_busy,
    input  logic [3:0]  i_nibble,
    input  logic [3:0]  i_reg_p,
    input  logic [19:0] i_current_pc,
    output logic [4:0]  o_alu_reg_dest,
    output logic [4:0]  o_alu_reg_src_1,
    output logic [4:0]  o_alu_reg_src_2,
    output logic [3:0]  o_alu_imm_value,
    output logic [4:0]  o_alu_opcode,
    output logic [2:0]  o_jump_length,
    output logic [3:0]  o_instr_type,
    output logic        o_instr_decoded,
    output logic        o_instr_execute
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PSET   = 2'd1,
        ST_OP2    = 2'd2,
        ST_OFFSET = 2'd3
    } state_t;

    localparam logic [4:0] REG_P    = 5'd20;
    localparam logic [4:0] REG_IMM  = 5'd30;
    localparam logic [4:0] REG_NONE = 5'd31;
    localparam logic [4:0] OP_COPY  = 5'd0;
    localparam logic [4:0] OP_NONE  = 5'd31;
    localparam logic [3:0] T_NOP    = 4'd0;
    localparam logic [3:0] T_ALU    = 4'd1;
    localparam logic [3:0] T_JUMP   = 4'd2;
    localparam logic [3:0] T_INV    = 4'd15;

    state_t      r_state, w_state;
    logic [2:0]  r_ofs_cnt, w_ofs_cnt;
    logic        r_nop3, w_nop3;
    logic [4:0]  r_dest, w_dest, r_src1, w_src1, r_src2, w_src2, r_opcode, w_opcode;
    logic [3:0]  r_imm, w_imm, r_type, w_type;
    logic [2:0]  r_jlen, w_jlen;
    logic        r_decoded, w_decoded, r_execute, w_execute;
    logic        w_sample;
    logic        w_unused;

    assign w_sample = i_clk_en & i_phases[1] & ~i_bus_busy;
    assign w_unused = ^{i_phase, i_cycle_ctr, i_reg_p, i_current_pc, i_phases[3:2], i_phases[0]};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_ofs_cnt <= '0;
            r_nop3    <= 1'b0;
            r_dest    <= REG_NONE;
            r_src1    <= REG_NONE;
            r_src2    <= REG_NONE;
            r_opcode  <= OP_NONE;
            r_imm     <= '0;
            r_type    <= T_NOP;
            r_jlen    <= '0;
            r_decoded <= 1'b0;
            r_execute <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_ofs_cnt <= w_ofs_cnt;
            r_nop3    <= w_nop3;
            r_dest    <= w_dest;
            r_src1    <= w_src1;
            r_src2    <= w_src2;
            r_opcode  <= w_opcode;
            r_imm     <= w_imm;
            r_type    <= w_type;
            r_jlen    <= w_jlen;
            r_decoded <= w_decoded;
            r_execute <= w_execute;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_ofs_cnt = r_ofs_cnt;
        w_nop3    = r_nop3;
        w_dest    = r_dest;
        w_src1    = r_src1;
        w_src2    = r_src2;
        w_opcode  = r_opcode;
        w_imm     = r_imm;
        w_type    = r_type;
        w_jlen    = r_jlen;
        w_decoded = r_decoded;
        w_execute = r_execute;

        if (w_sample) begin
            case (r_state)
                ST_IDLE: begin
                    // First nibble of a new instruction: wipe everything left by the last one.
                    w_dest    = REG_NONE;
                    w_src1    = REG_NONE;
                    w_src2    = REG_NONE;
                    w_opcode  = OP_NONE;
                    w_imm     = '0;
                    w_type    = T_NOP;
                    w_jlen    = '0;
                    w_decoded = 1'b0;
                    w_execute = 1'b0;
                    w_ofs_cnt = '0;
                    w_nop3    = 1'b0;
                    case (i_nibble)
                        4'h2: begin
                            w_decoded = 1'b1;
                            w_state   = ST_PSET;
                        end
                        4'h4: begin
                            w_type    = T_JUMP;
                            w_jlen    = 3'd2;
                            w_decoded = 1'b1;
                            w_nop3    = 1'b1;
                            w_state   = ST_OFFSET;
                        end
                        4'h6, 4'h7: begin
                            w_type    = T_JUMP;
                            w_jlen    = 3'd3;
                            w_decoded = 1'b1;
                            w_state   = ST_OFFSET;
                        end
                        4'h8: w_state = ST_OP2;
                        default: begin
                            w_type    = T_INV;
                            w_decoded = 1'b1;
                            w_execute = 1'b1;
                        end
                    endcase
                end
                ST_PSET: begin
                    w_type    = T_ALU;
                    w_dest    = REG_P;
                    w_src1    = REG_IMM;
                    w_src2    = REG_NONE;
                    w_imm     = i_nibble;
                    w_opcode  = OP_COPY;
                    w_decoded = 1'b1;
                    w_execute = 1'b1;
                    w_state   = ST_IDLE;
                end
                ST_OP2: begin
                    w_decoded = 1'b1;
                    w_type    = T_INV;
                    w_execute = 1'b1;
                    w_state   = ST_IDLE;
`ifdef SATURN_DEC_LONGJMP_EN
                    case (i_nibble)
                        4'hC, 4'hE: begin
                            w_type    = T_JUMP;
                            w_jlen    = 3'd4;
                            w_execute = 1'b0;
                            w_state   = ST_OFFSET;
                        end
                        4'hD, 4'hF: begin
                            w_type    = T_JUMP;
                            w_jlen    = 3'd5;
                            w_execute = 1'b0;
                            w_state   = ST_OFFSET;
                        end
                        default: ;
                    endcase
`endif
                end
                ST_OFFSET: begin
                    w_ofs_cnt = r_ofs_cnt + 3'd1;
                    // NOP3 is GOC with offset nibbles 2 then 0.
                    if (r_ofs_cnt == 3'd0)
                        w_nop3 = r_nop3 & (i_nibble == 4'h2);
                    else if (r_ofs_cnt == 3'd1)
                        w_nop3 = r_nop3 & (i_nibble == 4'h0);
                    if (w_ofs_cnt == r_jlen) begin
                        w_execute = 1'b1;
                        w_type    = w_nop3 ? T_NOP : T_JUMP;
                        w_state   = ST_IDLE;
                    end
                end
                default: w_state = ST_IDLE;
            endcase
        end
    end

    assign o_alu_reg_dest  = r_dest;
    assign o_alu_reg_src_1 = r_src1;
    assign o_alu_reg_src_2 = r_src2;
    assign o_alu_imm_value = r_imm;
    assign o_alu_opcode    = r_opcode;
    assign o_jump_length   = r_jlen;
    assign o_instr_type    = r_type;
    assign o_instr_decoded = r_decoded;
    assign o_instr_execute = r_execute;

endmodule

// File: tb/tb_saturn_inst_decoder.sv
// Directed self-checking bench for saturn_inst_decoder; long-jump checks follow SATURN_DEC_LONGJMP_EN.
module tb_saturn_inst_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_en = 1'b1;
    logic [3:0]  phases = 4'b0001;
    logic        busy = 1'b0;
    logic [3:0]  nib = '0;
    logic [4:0]  dest, src1, src2, opcode;
    logic [3:0]  imm, itype;
    logic [2:0]  jlen;
    logic        decoded, execute;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    saturn_inst_decoder dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_clk_en        (clk_en),
        .i_phases        (phases),
        .i_phase         (2'd1),
        .i_cycle_ctr     (32'd0),
        .i_bus_busy      (busy),
        .i_nibble        (nib),
        .i_reg_p         (4'd0),
        .i_current_pc    (20'd0),
        .o_alu_reg_dest  (dest),
        .o_alu_reg_src_1 (src1),
        .o_alu_reg_src_2 (src2),
        .o_alu_imm_value (imm),
        .o_alu_opcode    (opcode),
        .o_jump_length   (jlen),
        .o_instr_type    (itype),
        .o_instr_decoded (decoded),
        .o_instr_execute (execute)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One bus round: phase 1 with the given busy flag, then an idle phase.
    task automatic round(input logic [3:0] n, input logic b);
        @(negedge clk);
        phases = 4'b0010;
        nib    = n;
        busy   = b;
        @(posedge clk);
        #1;
        phases = 4'b0100;
        busy   = 1'b0;
    endtask

    task automatic sample(input logic [3:0] n);
        round(n, 1'b0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".type"}, itype, 0);
        chk({tag, ".dec"}, decoded, 0);
        chk({tag, ".exe"}, execute, 0);
        chk({tag, ".dest"}, dest, 31);
        chk({tag, ".src1"}, src1, 31);
        chk({tag, ".opc"}, opcode, 31);
        chk({tag, ".jlen"}, jlen, 0);
        chk({tag, ".imm"}, imm, 0);
    endtask

    initial begin
        #12;
        chk_reset("rst");
        @(negedge clk);
        rst = 1'b0;

        // P=5
        sample(4'h2);
        chk("p.dec1", decoded, 1);
        chk("p.exe1", execute, 0);
        sample(4'h5);
        chk("p.type", itype, 1);
        chk("p.dest", dest, 20);
        chk("p.src1", src1, 30);
        chk("p.src2", src2, 31);
        chk("p.imm", imm, 5);
        chk("p.opc", opcode, 0);
        chk("p.dec", decoded, 1);
        chk("p.exe", execute, 1);

        // clock enable low: nothing changes
        clk_en = 1'b0;
        round(4'h6, 1'b0);
        chk("cen.exe", execute, 1);
        chk("cen.type", itype, 1);
        clk_en = 1'b1;

        // GOTO 6,1,2,3
        sample(4'h6);
        chk("goto.type", itype, 2);
        chk("goto.jlen", jlen, 3);
        chk("goto.dec", decoded, 1);
        chk("goto.exe", execute, 0);
        chk("goto.dest", dest, 31);
        chk("goto.opc", opcode, 31);
        sample(4'h1);
        chk("goto.exe2", execute, 0);
        sample(4'h2);
        chk("goto.exe3", execute, 0);
        sample(4'h3);
        chk("goto.exe4", execute, 1);
        chk("goto.type4", itype, 2);

        // NOP3 = 4,2,0
        sample(4'h4);
        chk("nop3.type", itype, 2);
        chk("nop3.jlen", jlen, 2);
        sample(4'h2);
        chk("nop3.type2", itype, 2);
        chk("nop3.exe2", execute, 0);
        sample(4'h0);
        chk("nop3.type3", itype, 0);
        chk("nop3.exe3", execute, 1);

        // GOC 4,5,0 is a real jump
        sample(4'h4);
        sample(4'h5);
        sample(4'h0);
        chk("goc.type", itype, 2);
        chk("goc.exe", execute, 1);

        // Invalid first nibble
        sample(4'h0);
        chk("inv.type", itype, 15);
        chk("inv.dec", decoded, 1);
        chk("inv.exe", execute, 1);

        // 8D long jump
        sample(4'h8);
        chk("lj.dec0", decoded, 0);
        chk("lj.exe0", execute, 0);
        sample(4'hD);
`ifdef SATURN_DEC_LONGJMP_EN
        chk("lj.type", itype, 2);
        chk("lj.jlen", jlen, 5);
        chk("lj.dec", decoded, 1);
        for (int i = 1; i <= 4; i++) begin
            sample(4'(i));
            chk("lj.exe_mid", execute, 0);
        end
        sample(4'h5);
        chk("lj.exe", execute, 1);
        chk("lj.type_end", itype, 2);
`else
        chk("lj.type", itype, 15);
        chk("lj.dec", decoded, 1);
        chk("lj.exe", execute, 1);
`endif

        // GOTO with busy rounds interleaved
        sample(4'h6);
        for (int i = 0; i < 3; i++) begin
            round(4'h0, 1'b1);
            chk("busy.exe", execute, 0);
            chk("busy.type", itype, 2);
        end
        @(negedge clk);
        phases = 4'b0100;
        nib    = 4'h0;
        @(posedge clk);
        #1;
        sample(4'h0);
        sample(4'h0);
        chk("busy.exe2", execute, 0);
        sample(4'h0);
        chk("busy.exe3", execute, 1);

        // Reset mid-offset, asynchronously
        sample(4'h6);
        sample(4'h1);
        sample(4'h2);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset("arst");
        @(negedge clk);
        rst = 1'b0;
        sample(4'h2);
        sample(4'h7);
        chk("post.type", itype, 1);
        chk("post.imm", imm, 7);
        chk("post.exe", execute, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1);
    end

endmodule
